// File: rtl/rp_8bit_trace.sv
// Instruction trace capture for the rp_8bit core fetch bus.
// Reassembles two-word instructions and queues records for a logger.
module rp_8bit_trace #(
  parameter int PAW   = 11,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bus_vld,
  input  logic [PAW-1:0] bus_adr,
  input  logic [15:0]    bus_rdt,
  input  logic           bus_flush,
  output logic           trc_vld,
  input  logic           trc_rdy,
  output logic [PAW-1:0] trc_adr,
  output logic [15:0]    trc_code,
  output logic [15:0]    trc_ext,
  output logic           trc_wide,
  output logic           trc_err,
  output logic [7:0]     drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] S_FIRST = 1'b0;
  localparam logic [0:0] S_EXT   = 1'b1;

  typedef struct packed {
    logic [PAW-1:0] adr;
    logic [15:0]    code;
    logic [15:0]    ext;
    logic           wide;
    logic           err;
  } rec_t;

  logic [0:0]     r_state;
  logic [PAW-1:0] r_hadr;
  logic [15:0]    r_hcode;
  rec_t           r_mem [DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  logic [7:0]     r_drop;

  logic [0:0]     w_nxt;
  logic           w_wide;
  logic           w_in_ext;
  logic           w_push;
  logic           w_hold;
  logic           w_xdrop;
  rec_t           w_rec;
  rec_t           w_head;
  logic [PAW-1:0] w_hadr_inc;
  logic           w_full;
  logic           w_pop;
  logic           w_acc;
  logic [1:0]     w_drops;
  logic [8:0]     w_dsum;

  // lds/sts and jmp/call carry a second word
  assign w_wide =
    (bus_rdt[15:10] == 6'b100100 && bus_rdt[3:0] == 4'b0000) ||
    (bus_rdt[15:9] == 7'b1001010 && bus_rdt[3:2] == 2'b11);

  assign w_hadr_inc = r_hadr + PAW'(1);
  assign w_in_ext   = (r_state == S_EXT) && !bus_flush;

  // Next-state, push request and held-word capture
  always_comb begin
    w_nxt   = w_in_ext ? S_EXT : S_FIRST;
    w_push  = 1'b0;
    w_hold  = 1'b0;
    w_xdrop = 1'b0;
    w_rec   = '0;
    if (bus_vld) begin
      if (w_in_ext) begin
        w_push      = 1'b1;
        w_rec.adr   = r_hadr;
        w_rec.code  = r_hcode;
        w_rec.wide  = 1'b1;
        if (bus_adr == w_hadr_inc) begin
          w_rec.ext = bus_rdt;
          w_nxt     = S_FIRST;
        end else begin
          w_rec.err = 1'b1;
          if (w_wide) begin
            w_hold = 1'b1;
            w_nxt  = S_EXT;
          end else begin
            w_xdrop = 1'b1;
            w_nxt   = S_FIRST;
          end
        end
      end else if (w_wide) begin
        w_hold = 1'b1;
        w_nxt  = S_EXT;
      end else begin
        w_push     = 1'b1;
        w_rec.adr  = bus_adr;
        w_rec.code = bus_rdt;
        w_nxt      = S_FIRST;
      end
    end
  end

  assign trc_vld = (r_wptr != r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = trc_vld & trc_rdy;
  assign w_acc   = w_push & (!w_full | w_pop);

  assign w_drops = {1'b0, w_push & ~w_acc} + {1'b0, w_xdrop};
  assign w_dsum  = {1'b0, r_drop} + {7'b0, w_drops};

  // FSM state and held first word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FIRST;
      r_hadr  <= '0;
      r_hcode <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_hold) begin
        r_hadr  <= bus_adr;
        r_hcode <= bus_rdt;
      end
    end
  end

  // Record FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_acc) begin
        r_mem[r_wptr[AW-1:0]] <= w_rec;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Saturating count of lost records
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop <= '0;
    else        r_drop <= w_dsum[8] ? 8'hFF : w_dsum[7:0];
  end

  assign w_head   = r_mem[r_rptr[AW-1:0]];
  assign trc_adr  = w_head.adr;
  assign trc_code = w_head.code;
  assign trc_ext  = w_head.ext;
  assign trc_wide = w_head.wide;
  assign trc_err  = w_head.err;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_rp_8bit_trace.sv
// Scoreboard bench for rp_8bit_trace.
// Directed vectors; a monitor checks every head record.
module tb_rp_8bit_trace;

  localparam int PAW   = 11;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [PAW-1:0] adr;
    logic [15:0]    code;
    logic [15:0]    ext;
    logic           wide;
    logic           err;
  } rec_t;

  logic           clk = 0;
  logic           rst_n = 0;
  logic           bus_vld = 0;
  logic [PAW-1:0] bus_adr = '0;
  logic [15:0]    bus_rdt = '0;
  logic           bus_flush = 0;
  logic           trc_vld;
  logic           trc_rdy = 0;
  logic [PAW-1:0] trc_adr;
  logic [15:0]    trc_code;
  logic [15:0]    trc_ext;
  logic           trc_wide;
  logic           trc_err;
  logic [7:0]     drop_cnt;

  int total = 0;
  int bad   = 0;
  rec_t exp_q[$];

  rp_8bit_trace #(.PAW(PAW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_vld(bus_vld), .bus_adr(bus_adr),
    .bus_rdt(bus_rdt), .bus_flush(bus_flush),
    .trc_vld(trc_vld), .trc_rdy(trc_rdy),
    .trc_adr(trc_adr), .trc_code(trc_code),
    .trc_ext(trc_ext), .trc_wide(trc_wide),
    .trc_err(trc_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [PAW-1:0] a,
                              input logic [15:0] c,
                              input logic [15:0] e,
                              input logic w, input logic er);
    rec_t r;
    r.adr = a; r.code = c; r.ext = e;
    r.wide = w; r.err = er;
    return r;
  endfunction

  // Monitor: head must match scoreboard; pop on handshake
  initial begin
    rec_t act;
    forever begin
      @(negedge clk);
      if (rst_n && trc_vld) begin
        act = mk(trc_adr, trc_code, trc_ext,
                 trc_wide, trc_err);
        if (exp_q.size() == 0) begin
          chk("unexpected_rec", 64'(act), 64'hDEAD);
        end else begin
          chk("rec", 64'(act), 64'(exp_q[0]));
          if (trc_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic word(input logic [PAW-1:0] a,
                      input logic [15:0] d,
                      input logic fl);
    bus_vld = 1; bus_adr = a;
    bus_rdt = d; bus_flush = fl;
    @(posedge clk); #1;
    bus_vld = 0; bus_flush = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 &&
         (exp_q.size() != 0 || trc_vld); i++)
      @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size() == 0 && !trc_vld), 64'd1);
  endtask

  task automatic reset_chk(input string nm);
    chk({nm, "_vld"}, 64'(trc_vld), 64'd0);
    chk({nm, "_adr"}, 64'(trc_adr), 64'd0);
    chk({nm, "_code"}, 64'(trc_code), 64'd0);
    chk({nm, "_ext"}, 64'({trc_ext, trc_wide, trc_err}), 64'd0);
    chk({nm, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    #2;
    reset_chk("rst0");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    trc_rdy = 1;

    // single word, one-cycle latency
    exp_q.push_back(mk(11'h010, 16'hE505, 0, 0, 0));
    word(11'h010, 16'hE505, 0);
    chk("single_lat", 64'(trc_vld), 64'd1);
    idle(2);

    // two-word with gap
    word(11'h020, 16'h9310, 0);
    idle(2);
    chk("gap_norec", 64'(trc_vld), 64'd0);
    exp_q.push_back(mk(11'h020, 16'h9310, 16'h0100, 1, 0));
    word(11'h021, 16'h0100, 0);
    chk("wide_lat", 64'(trc_vld), 64'd1);
    drain();

    // flush with same-cycle word
    word(11'h030, 16'h940C, 0);
    exp_q.push_back(mk(11'h040, 16'hE505, 0, 0, 0));
    word(11'h040, 16'hE505, 1);
    drain();
    chk("flush_drop", 64'(drop_cnt), 64'd0);

    // address break
    word(11'h050, 16'h940C, 0);
    exp_q.push_back(mk(11'h050, 16'h940C, 0, 1, 1));
    word(11'h060, 16'hE505, 0);
    chk("brk_drop", 64'(drop_cnt), 64'd1);
    drain();

    // reset between groups
    rst_n = 0; #1;
    reset_chk("rst1");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // overflow with consumer stalled
    trc_rdy = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i < DEPTH)
        exp_q.push_back(mk(11'(16'h100 + i),
                           16'(16'hE000 + i), 0, 0, 0));
      word(11'(16'h100 + i), 16'(16'hE000 + i), 0);
    end
    chk("ovf_drop", 64'(drop_cnt), 64'd3);
    chk("ovf_full", 64'(trc_vld), 64'd1);

    // full FIFO with same-cycle pop accepts pushes
    trc_rdy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(mk(11'(16'h200 + i),
                         16'(16'hE100 + i), 0, 0, 0));
      word(11'(16'h200 + i), 16'(16'hE100 + i), 0);
    end
    drain();
    chk("thru_drop", 64'(drop_cnt), 64'd3);

    // address wrap pair
    word(11'h7FF, 16'h940E, 0);
    exp_q.push_back(mk(11'h7FF, 16'h940E, 16'h1234, 1, 0));
    word(11'h000, 16'h1234, 0);
    drain();

    // reset mid-stream with FIFO contents and a held word
    trc_rdy = 0;
    exp_q.push_back(mk(11'h001, 16'hE505, 0, 0, 0));
    word(11'h001, 16'hE505, 0);
    word(11'h002, 16'h9310, 0);
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    exp_q.delete();
    reset_chk("rst2");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    trc_rdy = 1;
    exp_q.push_back(mk(11'h003, 16'h0100, 0, 0, 0));
    word(11'h003, 16'h0100, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
